gauss_sched: RTL
================

GAUSS_SCHED -- requirements
Module: gauss_sched

Interface
REQ-001 Parameter OUT_DIM, default 6, SHALL set the output tile dimension (OUT_DIM x OUT_DIM windows per tile).
REQ-002 Parameter GAUSS_LAT, default 2, SHALL set the number of cycles (>=1) that win_buf_full is held per window.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port n_rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port start  input  1  SHALL request processing of one tile; sampled only in IDLE.
REQ-006 Port abort  input  1  SHALL be a synchronous cancel of the current tile.
REQ-007 Port win_ready  input  1  SHALL indicate that the window buffer holds a valid 3x3 window.
REQ-008 Port sobel_ack  input  1  SHALL indicate that the Sobel stage has accepted the completed tile.
REQ-009 Port win_req  output  1  SHALL request the next 3x3 window from the window buffer.
REQ-010 Port win_row, win_col  output  3 each  SHALL give the tile coordinates of the current window.
REQ-011 Port win_buf_full  output  1  SHALL be the compute enable driven to the Gaussian filter wrapper.
REQ-012 Port sobel_en  output  1  SHALL signal that a full OUT_DIM x OUT_DIM Gaussian tile is ready.
REQ-013 Port win_count  output  6  SHALL give the number of windows completed in the current tile.
REQ-014 Port busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ, WAIT, COMPUTE, ADVANCE and HANDOFF.
REQ-016 IDLE: start=1 SHALL clear win_row, win_col and win_count to 0 and go to REQ; otherwise the FSM stays in IDLE.
REQ-017 REQ: win_req SHALL be 1 for exactly this one cycle, then the FSM goes to WAIT.
REQ-018 WAIT: the FSM SHALL stay until win_ready=1, then load the latency counter with GAUSS_LAT-1 and go to COMPUTE.
REQ-019 COMPUTE: win_buf_full SHALL be 1 for exactly GAUSS_LAT cycles; when the counter is 0 the FSM goes to ADVANCE.
REQ-020 ADVANCE: win_count SHALL increment by 1, and win_col SHALL increment.
REQ-021 ADVANCE wrap: at win_col=OUT_DIM-1, win_col SHALL wrap to 0 and win_row SHALL increment.
REQ-022 ADVANCE exit: at win_row=OUT_DIM-1 and win_col=OUT_DIM-1 the FSM SHALL go to HANDOFF with win_row/win_col held; otherwise it goes to REQ.
REQ-023 HANDOFF: sobel_en SHALL be 1 in every cycle until sobel_ack=1; the FSM then goes to IDLE, and sobel_en is 0 from the next cycle.
REQ-024 sobel_ack outside HANDOFF SHALL be ignored.
REQ-025 win_req, win_buf_full and sobel_en SHALL be Moore outputs, decoded from registered state only, and mutually exclusive.
REQ-026 abort=1 in any state SHALL force IDLE on the next edge with all outputs deasserted; win_count is retained.
REQ-027 abort and start asserted together in IDLE: abort SHALL win and the FSM stays in IDLE.
REQ-028 start asserted outside IDLE SHALL be ignored, with no queuing.
REQ-029 With win_ready held at 1, each window SHALL take exactly GAUSS_LAT+3 cycles: REQ, WAIT, COMPUTE, ADVANCE.
REQ-030 win_ready dropping during COMPUTE SHALL NOT stall COMPUTE.

Reset
REQ-031 While n_rst=0, asynchronously: the FSM SHALL be in IDLE and all outputs, counters and coordinates SHALL be 0.
REQ-032 Reset asserted mid-tile SHALL discard all progress; after release, a new start is required.

Verification
REQ-033 Reset then release, inputs 0 -> all outputs 0, busy=0 indefinitely.
REQ-034 Nominal tile: start pulse, win_ready=1, defaults. Required response:
  - win_buf_full high exactly 72 cycles total;
  - sobel_en rises 180 cycles after the edge sampling start, and win_count=36 at that point;
  - win_row/win_col sequence (0,0),(0,1)..(0,5),(1,0)..(5,5).
REQ-035 Stall: win_ready held 0 for 7 cycles in WAIT of window 3 -> win_buf_full stays 0 during the stall; tile completes 7 cycles later (edge 187).
REQ-036 Handoff: sobel_ack held 0 for 10 cycles in HANDOFF -> sobel_en held for 11 cycles; busy=0 on the cycle after ack.
REQ-037 abort asserted during COMPUTE of window 10 -> IDLE next edge, win_buf_full=0, win_count=9.
REQ-037 (cont.) A subsequent start restarts at (0,0) with win_count=0.
REQ-038 Start in a busy state, and abort+start together in IDLE -> both ignored; n_rst pulse mid-tile -> immediate IDLE, all outputs 0.

Source files
------------

// File: rtl/gauss_sched.sv
// Window scheduler for the Gaussian stage: walks an OUT_DIM x OUT_DIM tile one 3x3 window at
// a time, gates the filter for GAUSS_LAT cycles per window, then hands the tile to Sobel.
module gauss_sched #(
    parameter int unsigned OUT_DIM   = 6,
    parameter int unsigned GAUSS_LAT = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       abort,
    input  logic       win_ready,
    input  logic       sobel_ack,
    output logic       win_req,
    output logic [2:0] win_row,
    output logic [2:0] win_col,
    output logic       win_buf_full,
    output logic       sobel_en,
    output logic [5:0] win_count,
    output logic       busy
);

    localparam int unsigned     LatW    = (GAUSS_LAT > 1) ? $clog2(GAUSS_LAT) : 1;
    localparam logic [2:0]      LastIdx = 3'(OUT_DIM - 1);
    localparam logic [LatW-1:0] LatLoad = LatW'(GAUSS_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StCompute,
        StAdvance,
        StHandoff
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      row_q, row_d;
    logic [2:0]      col_q, col_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [LatW-1:0] lat_q, lat_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        // Abort overrides everything, including a simultaneous start; progress counters are kept.
        if (abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        row_d   = '0;
                        col_d   = '0;
                        cnt_d   = '0;
                        state_d = StReq;
                    end
                end
                StReq: state_d = StWait;
                StWait: begin
                    if (win_ready) begin
                        lat_d   = LatLoad;
                        state_d = StCompute;
                    end
                end
                StCompute: begin
                    if (lat_q == '0) begin
                        state_d = StAdvance;
                    end else begin
                        lat_d = lat_q - LatW'(1);
                    end
                end
                StAdvance: begin
                    cnt_d = cnt_q + 6'd1;
                    if (col_q == LastIdx) begin
                        if (row_q == LastIdx) begin
                            // Final window: coordinates stay on the last position.
                            state_d = StHandoff;
                        end else begin
                            col_d   = '0;
                            row_d   = row_q + 3'd1;
                            state_d = StReq;
                        end
                    end else begin
                        col_d   = col_q + 3'd1;
                        state_d = StReq;
                    end
                end
                StHandoff: begin
                    if (sobel_ack) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign win_req      = (state_q == StReq);
    assign win_buf_full = (state_q == StCompute);
    assign sobel_en     = (state_q == StHandoff);
    assign busy         = (state_q != StIdle);
    assign win_row      = row_q;
    assign win_col      = col_q;
    assign win_count    = cnt_q;

endmodule
